chan_err_inj: RTL and testbench

- Synthesizable binary-symmetric-channel emulator between the rate-1/2 convolutional encoder (2-bit symbols) and the Viterbi decoder.
- Corrupts encoded symbols pseudo-randomly at rate 2^-N, with configurable burst length and bit-flip pattern.
- Reports per-symbol error flags and running symbol and bit-error counts, so decoder correction capability can be characterized on FPGA and in simulation.

---
 rtl/chan_pkg.sv | 31 +++
 rtl/lfsr_galois.sv | 27 ++
 rtl/chan_err_inj.sv | 153 +++++++++++++++
 tb/tb_chan_err_inj.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_pkg.sv
// Shared types and constants for the channel error injector.
// The mode-to-mask mapping lives here so the top reads as pure control flow.
package chan_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    FLIP0    = 2'b00,
    FLIP1    = 2'b01,
    FLIPBOTH = 2'b10,
    ALT      = 2'b11
  } mode_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [1:0] flip_mask(input mode_t mode, input logic alt);
    logic [1:0] mask;
    unique case (mode)
      FLIP0:    mask = 2'b01;
      FLIP1:    mask = 2'b10;
      FLIPBOTH: mask = 2'b11;
      default:  mask = alt ? 2'b10 : 2'b01;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR that steps only when adv_i is high.
module lfsr_galois #(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = 16'hB400,
  parameter logic [W-1:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0] r_state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEED;
    end else if (adv_i) begin
      r_state <= (r_state >> 1) ^ (r_state[0] ? TAPS : '0);
    end
  end

  assign state_o = r_state;

endmodule

// File: rtl/chan_err_inj.sv
// Binary-symmetric-channel emulator: corrupts 2-bit symbols in bursts
// triggered by an LFSR and keeps saturating symbol / bit-error statistics.
module chan_err_inj
  import chan_pkg::*;
#(
  parameter int                N         = 4,
  parameter int                BURST_LEN = 2,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED,
  parameter int                CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [1:0]       sym_i,
  input  logic             inj_en_i,
  input  logic [1:0]       mode_i,
  input  logic             clr_i,
  output logic             valid_o,
  output logic [1:0]       sym_o,
  output logic             err_flag_o,
  output logic [CNT_W-1:0] sym_ct_o,
  output logic [CNT_W-1:0] bit_err_ct_o
);

  localparam int                REM_W     = $clog2(BURST_LEN + 1);
  localparam logic [REM_W-1:0]  BURST_REM = REM_W'(BURST_LEN - 1);
  localparam logic [LFSR_W-1:0] TRIG_MASK = LFSR_W'((64'd1 << N) - 64'd1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [LFSR_W-1:0] w_lfsr;
  logic              w_trigger;
  state_t            r_state, w_state_nxt;
  logic [REM_W-1:0]  r_rem, w_rem_nxt;
  logic              r_alt, w_alt_nxt;
  logic              w_alt_use;
  logic              w_corrupt;
  logic [1:0]        w_mask;
  logic [1:0]        w_bits;
  logic [CNT_W:0]    w_bit_sum;
  logic              r_valid, r_err;
  logic [1:0]        r_sym;
  logic [CNT_W-1:0]  r_sym_ct, r_bit_ct;

  // Stepping only on valid symbols ties the error pattern to symbol index.
  lfsr_galois #(
    .W    (LFSR_W),
    .TAPS (LFSR_W'(LFSR_TAPS)),
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (enable_i),
    .state_o (w_lfsr)
  );

  assign w_trigger = (w_lfsr & TRIG_MASK) == TRIG_MASK;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_alt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_alt   <= w_alt_nxt;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_alt_nxt   = r_alt;
    if (enable_i) begin
      unique case (r_state)
        IDLE: begin
          if (inj_en_i && w_trigger && (BURST_LEN > 1)) begin
            w_state_nxt = BURST;
            w_rem_nxt   = BURST_REM;
            w_alt_nxt   = 1'b1;
          end
        end
        BURST: begin
          if (inj_en_i) begin
            w_rem_nxt = r_rem - REM_W'(1);
            w_alt_nxt = ~r_alt;
            if (r_rem == REM_W'(1)) w_state_nxt = IDLE;
          end else begin
            w_state_nxt = IDLE;
            w_rem_nxt   = '0;
            w_alt_nxt   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // The first symbol of a burst always sees alt=0, so ALT starts on bit0.
  always_comb begin
    w_corrupt = 1'b0;
    w_alt_use = 1'b0;
    if (enable_i && inj_en_i) begin
      unique case (r_state)
        IDLE:  w_corrupt = w_trigger;
        BURST: begin
          w_corrupt = 1'b1;
          w_alt_use = r_alt;
        end
        default: ;
      endcase
    end
    w_mask = w_corrupt ? flip_mask(mode_t'(mode_i), w_alt_use) : 2'b00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_sym   <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      r_valid <= enable_i;
      r_sym   <= enable_i ? (sym_i ^ w_mask) : 2'b00;
      r_err   <= w_corrupt;
    end
  end

  assign w_bits    = {1'b0, w_mask[1]} + {1'b0, w_mask[0]};
  assign w_bit_sum = {1'b0, r_bit_ct} + (CNT_W+1)'(w_bits);

  // Clear has priority over any event counted in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sym_ct <= '0;
      r_bit_ct <= '0;
    end else if (clr_i) begin
      r_sym_ct <= '0;
      r_bit_ct <= '0;
    end else begin
      if (enable_i && (r_sym_ct != CNT_MAX)) r_sym_ct <= r_sym_ct + CNT_W'(1);
      if (w_corrupt) r_bit_ct <= w_bit_sum[CNT_W] ? CNT_MAX : w_bit_sum[CNT_W-1:0];
    end
  end

  assign valid_o      = r_valid;
  assign sym_o        = r_sym;
  assign err_flag_o   = r_err;
  assign sym_ct_o     = r_sym_ct;
  assign bit_err_ct_o = r_bit_ct;

endmodule

// File: tb/tb_chan_err_inj.sv
// Scoreboard bench for chan_err_inj: a symbol-level channel model predicts
// every output symbol and the statistics counters.
module tb_chan_err_inj;

  localparam int          BL    = 2;
  localparam logic [15:0] NMASK = 16'h000F;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, inj = 1'b0, clr = 1'b0;
  logic [1:0] sym = 2'b00, mode = 2'b00;
  logic       valid_o, err_o;
  logic [1:0] sym_o;
  logic [15:0] sym_ct, bit_ct;

  logic       s_en = 1'b0, s_clr = 1'b0;
  logic       s_valid, s_err;
  logic [1:0] s_sym;
  logic [3:0] s_sym_ct, s_bit_ct;

  typedef struct packed {
    logic [1:0] sym;
    logic       flag;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0;
  logic [15:0] m_lfsr;
  int          m_left, m_pos, m_sym_ct, m_bit_ct;
  logic        m_valid;
  int          t2_bits;
  logic        pair_mode = 1'b0;
  int          run_len = 0;
  int          dut_flags = 0;

  always #5 clk = ~clk;

  chan_err_inj u_dut (
    .clk(clk), .rst(rst), .enable_i(en), .sym_i(sym), .inj_en_i(inj),
    .mode_i(mode), .clr_i(clr), .valid_o(valid_o), .sym_o(sym_o),
    .err_flag_o(err_o), .sym_ct_o(sym_ct), .bit_err_ct_o(bit_ct)
  );

  chan_err_inj #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .enable_i(s_en), .sym_i(2'b00), .inj_en_i(1'b0),
    .mode_i(2'b00), .clr_i(s_clr), .valid_o(s_valid), .sym_o(s_sym),
    .err_flag_o(s_err), .sym_ct_o(s_sym_ct), .bit_err_ct_o(s_bit_ct)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int sat_add(input int a, input int b, input int max);
    return (a + b > max) ? max : a + b;
  endfunction

  function automatic logic burst_starts_next();
    return (m_left == 0) && ((m_lfsr & NMASK) == NMASK);
  endfunction

  task automatic model_reset();
    m_lfsr   = 16'hACE1;
    m_left   = 0;
    m_pos    = 0;
    m_sym_ct = 0;
    m_bit_ct = 0;
    m_valid  = 1'b0;
  endtask

  // Drive one cycle of inputs, predict its outcome, then move past the edge.
  task automatic step(input logic e, input logic [1:0] s, input logic ij,
                      input logic [1:0] md, input logic c);
    logic       flag;
    logic [1:0] mask;
    exp_t       x;
    en = e; sym = s; inj = ij; mode = md; clr = c;
    flag = 1'b0;
    mask = 2'b00;
    if (e) begin
      if (m_left > 0) begin
        if (ij) begin
          flag = 1'b1;
          m_pos++;
          m_left--;
        end else begin
          m_left = 0;
        end
      end else if (ij && ((m_lfsr & NMASK) == NMASK)) begin
        flag   = 1'b1;
        m_pos  = 0;
        m_left = BL - 1;
      end
      if (flag) begin
        case (md)
          2'd0:    mask = 2'b01;
          2'd1:    mask = 2'b10;
          2'd2:    mask = 2'b11;
          default: mask = (m_pos % 2 == 0) ? 2'b01 : 2'b10;
        endcase
      end
      m_lfsr = lfsr_next(m_lfsr);
      x.sym  = s ^ mask;
      x.flag = flag;
      q.push_back(x);
    end
    if (c) begin
      m_sym_ct = 0;
      m_bit_ct = 0;
    end else if (e) begin
      m_sym_ct = sat_add(m_sym_ct, 1, 65535);
      m_bit_ct = sat_add(m_bit_ct, int'(mask[0]) + int'(mask[1]), 65535);
    end
    m_valid = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_valid_o"}, valid_o, m_valid);
    check({tag, "_sym_ct"}, sym_ct, m_sym_ct);
    check({tag, "_bit_ct"}, bit_ct, m_bit_ct);
  endtask

  task automatic do_reset();
    en = 1'b0; inj = 1'b0; clr = 1'b0; sym = 2'b00; mode = 2'b00;
    rst = 1'b0;
    q.delete();
    model_reset();
    pair_mode = 1'b0;
    run_len   = 0;
    dut_flags = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_sym", sym_o, 0);
    check("rst_err", err_o, 0);
    check("rst_counts", {bit_ct, sym_ct}, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented symbol against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (valid_o) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=1 expected=0 time=%0t", $time);
        end else begin
          e = q.pop_front();
          check("sym_o", sym_o, e.sym);
          check("err_flag_o", err_o, e.flag);
        end
        if (err_o === 1'b1) begin
          dut_flags++;
          run_len++;
        end else begin
          if (pair_mode && run_len > 0) check("burst_pair", run_len % 2, 0);
          run_len = 0;
        end
      end else begin
        check("idle_sym_o", sym_o, 0);
        check("idle_err", err_o, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic started;
    model_reset();

    // Transparency
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b1, 2'(i % 4), 1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
    check_counts("t1");
    check("t1_sym_100", sym_ct, 100);
    check("t1_no_bits", bit_ct, 0);

    // Default injection, bursts of two
    do_reset();
    pair_mode = 1'b1;
    for (int i = 0; i < 256; i++) step(1'b1, 2'b00, 1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    check_counts("t2");
    t2_bits = m_bit_ct;
    check("t2_flags_eq_bits", dut_flags, t2_bits);

    // Gapped input, both bits flipped: same per-symbol pattern
    do_reset();
    pair_mode = 1'b1;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 2'b01, 1'b1, 2'b10, 1'b0);
      step(1'b0, 2'($urandom_range(3)), 1'b1, 2'b10, 1'b0);
    end
    step(1'b0, 2'b00, 1'b1, 2'b10, 1'b0);
    check_counts("t3");
    check("t3_double_bits", bit_ct, 2 * t2_bits);

    // Alternate mode
    do_reset();
    pair_mode = 1'b1;
    for (int i = 0; i < 256; i++) step(1'b1, 2'b00, 1'b1, 2'b11, 1'b0);
    step(1'b0, 2'b00, 1'b0, 2'b11, 1'b0);
    check_counts("t4");
    check("t4_bits", bit_ct, t2_bits);

    // Abort: drop inj_en on the second burst symbol
    do_reset();
    for (int i = 0; i < 300; i++) begin
      started = burst_starts_next();
      step(1'b1, 2'b00, 1'b1, 2'b00, 1'b0);
      if (started) begin
        check("abort_first_flag", err_o, 1);
        step(1'b1, 2'b10, 1'b0, 2'b00, 1'b0);
        check("abort_clean_flag", err_o, 0);
        check("abort_clean_sym", sym_o, 2'b10);
        for (int j = 0; j < 8; j++) step(1'b1, 2'b00, 1'b1, 2'b00, 1'b0);
        break;
      end
    end
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
    check_counts("t5a");

    // Reset mid-burst, then rerun the default injection
    do_reset();
    for (int i = 0; i < 300; i++) begin
      started = burst_starts_next();
      step(1'b1, 2'b00, 1'b1, 2'b00, 1'b0);
      if (started) break;
    end
    check("pre_rst_flag", err_o, 1);
    en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_valid", valid_o, 0);
    check("midrst_sym", sym_o, 0);
    check("midrst_err", err_o, 0);
    check("midrst_counts", {bit_ct, sym_ct}, 0);
    do_reset();
    pair_mode = 1'b1;
    for (int i = 0; i < 256; i++) step(1'b1, 2'b00, 1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
    check_counts("t5b");
    check("t5b_rerun_bits", bit_ct, t2_bits);

    // Randomised traffic including aborts, modes and clears
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(9) < 7), 2'($urandom_range(3)), ($urandom_range(7) != 0),
           2'($urandom_range(3)), ($urandom_range(49) == 0));
      if (i % 50 == 49) check_counts("rand");
    end
    step(1'b1, 2'b00, 1'b0, 2'b00, 1'b1);
    check_counts("clr_with_en");
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);

    // Saturation and clear on the narrow-counter instance
    for (int i = 0; i < 20; i++) begin
      s_en = 1'b1;
      @(posedge clk);
      #1;
    end
    s_en = 1'b0;
    @(posedge clk);
    #1;
    check("sat_sym_ct", s_sym_ct, 15);
    check("sat_bit_ct", s_bit_ct, 0);
    s_en  = 1'b1;
    s_clr = 1'b1;
    @(posedge clk);
    #1;
    check("sat_clr", s_sym_ct, 0);
    s_clr = 1'b0;
    @(posedge clk);
    #1;
    s_en = 1'b0;
    check("sat_after_clr", s_sym_ct, 1);

    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    #1;
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
